// File: rtl/tb_mmio_pkg.sv
// tb_mmio_pkg
// Shared definitions for the test-control MMIO responder: register offsets
// (decoded from addr[4:2]), default pass/fail signature values, the decoded
// register-select enum, the registered response record and a byte-lane
// write-merge helper.
package tb_mmio_pkg;

    localparam logic [2:0] OFF_PRINT       = 3'd0;
    localparam logic [2:0] OFF_TEST_STATUS = 3'd1;
    localparam logic [2:0] OFF_EXIT        = 3'd2;
    localparam logic [2:0] OFF_TIMER_CNT   = 3'd3;
    localparam logic [2:0] OFF_TIMER_CMP   = 3'd4;
    localparam logic [2:0] OFF_CYCLE       = 3'd5;

    localparam logic [31:0] DEFAULT_PASS_VALUE = 32'd123456789;
    localparam logic [31:0] DEFAULT_FAIL_VALUE = 32'd1;

    typedef enum logic [2:0] {
        SEL_PRINT,
        SEL_TEST_STATUS,
        SEL_EXIT,
        SEL_TIMER_CNT,
        SEL_TIMER_CMP,
        SEL_CYCLE,
        SEL_NONE
    } reg_sel_e;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    // Replace the byte lanes of old_val selected by be with those of new_val.
    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/tb_mmio_char_fifo.sv
// tb_mmio_char_fifo
// Synchronous 8-bit FIFO buffering stdout characters.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, data_i     write side; a push while full_o is dropped
//   full_o             FIFO holds DEPTH entries
//   pop_i              read side; only acts while valid_o
//   valid_o, data_o    head entry; data_o reads 0 while empty
// DEPTH must be a power of two and at least 2.
module tb_mmio_char_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] data_i,
    output logic       full_o,
    input  logic       pop_i,
    output logic       valid_o,
    output logic [7:0] data_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // indices with differing wrap bits mean full.
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]  mem_q [DEPTH];
    logic        empty, push_en, pop_en;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty;
    assign valid_o = ~empty;
    assign data_o  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: storage has no reset; entries are only observable once written,
    // because the pointers (which are reset) gate every read.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (pop_en)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/tb_mmio_responder.sv
// tb_mmio_responder
// OBI device that lets simulated software report test status, exit codes and
// stdout characters, and read a free-running cycle counter.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   data_req_i/gnt_o/addr_i/we_i/be_i/wdata_i   OBI request channel
//   data_rvalid_o/rdata_o/err_o    OBI response, one cycle after accept
//   char_valid_o/data_o/ready_i    stdout FIFO head and pop handshake
//   tests_passed_o/failed_o        one-cycle status pulses
//   exit_valid_o/exit_value_o      one-cycle exit pulse, held exit code
//   timer_irq_o                    timer interrupt level
// Build option: define TB_MMIO_TIMER_EN to enable TIMER_CNT/TIMER_CMP and the
// timer interrupt; otherwise those offsets respond with an error.
module tb_mmio_responder
    import tb_mmio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] PASS_VALUE = DEFAULT_PASS_VALUE,
    parameter logic [31:0] FAIL_VALUE = DEFAULT_FAIL_VALUE
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        char_valid_o,
    output logic [7:0]  char_data_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o,
    output logic        timer_irq_o
);

    reg_sel_e    sel;
    logic        sel_err, accept, wr_ok, fifo_full, fifo_push;
    logic [31:0] rdata_mux;
    rsp_t        rsp_d, rsp_q;
    logic        passed_d, passed_q, failed_d, failed_q;
    logic        exit_valid_d, exit_valid_q;
    logic [31:0] exit_value_d, exit_value_q;
    logic [31:0] cycle_q;

`ifdef TB_MMIO_TIMER_EN
    logic [31:0] cnt_d, cnt_q, cmp_d, cmp_q;
    logic        irq_d, irq_q;
`endif

    // Only addr[4:2] is decoded; the wrapper has already selected the window.
    logic unused_addr;
    assign unused_addr = ^{data_addr_i[31:5], data_addr_i[1:0]};

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sel = SEL_NONE;
        case (data_addr_i[4:2])
            OFF_PRINT:       sel = SEL_PRINT;
            OFF_TEST_STATUS: sel = SEL_TEST_STATUS;
            OFF_EXIT:        sel = SEL_EXIT;
`ifdef TB_MMIO_TIMER_EN
            OFF_TIMER_CNT:   sel = SEL_TIMER_CNT;
            OFF_TIMER_CMP:   sel = SEL_TIMER_CMP;
`endif
            OFF_CYCLE:       sel = SEL_CYCLE;
            default:         sel = SEL_NONE;
        endcase
    end

    always_comb begin
        sel_err = 1'b0;
        case (sel)
            SEL_PRINT, SEL_TEST_STATUS, SEL_EXIT: sel_err = ~data_we_i;
            SEL_CYCLE:                            sel_err = data_we_i;
            SEL_NONE:                             sel_err = 1'b1;
            default:                              sel_err = 1'b0;
        endcase
    end

    // A PRINT write stalls while the FIFO is full, judged before any pop in
    // the same cycle; the master holds the request until granted.
    assign data_gnt_o = data_req_i & ~(data_we_i & (sel == SEL_PRINT) & fifo_full);
    assign accept     = data_req_i & data_gnt_o;
    assign wr_ok      = accept & data_we_i & ~sel_err;
    assign fifo_push  = wr_ok & (sel == SEL_PRINT) & data_be_i[0];

    tb_mmio_char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_char_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (data_wdata_i[7:0]),
        .full_o  (fifo_full),
        .pop_i   (char_ready_i),
        .valid_o (char_valid_o),
        .data_o  (char_data_o)
    );

    always_comb begin
        rdata_mux = '0;
        if (!data_we_i && !sel_err) begin
            case (sel)
                SEL_CYCLE:     rdata_mux = cycle_q;
`ifdef TB_MMIO_TIMER_EN
                SEL_TIMER_CNT: rdata_mux = cnt_q;
                SEL_TIMER_CMP: rdata_mux = cmp_q;
`endif
                default:       rdata_mux = '0;
            endcase
        end
    end

    always_comb begin
        rsp_d.valid  = accept;
        rsp_d.err    = accept & sel_err;
        rsp_d.rdata  = accept ? rdata_mux : '0;
        passed_d     = wr_ok & (sel == SEL_TEST_STATUS) & (data_wdata_i == PASS_VALUE);
        failed_d     = wr_ok & (sel == SEL_TEST_STATUS) & (data_wdata_i == FAIL_VALUE);
        exit_valid_d = wr_ok & (sel == SEL_EXIT);
        exit_value_d = exit_valid_d ? data_wdata_i : exit_value_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_q        <= '0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_value_q <= '0;
            cycle_q      <= '0;
        end else begin
            rsp_q        <= rsp_d;
            passed_q     <= passed_d;
            failed_q     <= failed_d;
            exit_valid_q <= exit_valid_d;
            exit_value_q <= exit_value_d;
            cycle_q      <= cycle_q + 32'd1;
        end
    end

`ifdef TB_MMIO_TIMER_EN
    // A bus write to TIMER_CNT replaces the increment for that cycle; a
    // TIMER_CMP write clears the interrupt even if a match is seen that cycle.
    always_comb begin
        cnt_d = cnt_q + 32'd1;
        cmp_d = cmp_q;
        irq_d = irq_q;
        if ((cnt_q == cmp_q) && (cmp_q != '0)) irq_d = 1'b1;
        if (wr_ok && (sel == SEL_TIMER_CNT)) cnt_d = apply_be(cnt_q, data_wdata_i, data_be_i);
        if (wr_ok && (sel == SEL_TIMER_CMP)) begin
            cmp_d = apply_be(cmp_q, data_wdata_i, data_be_i);
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            cmp_q <= '0;
            irq_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign timer_irq_o = irq_q;
`else
    // Upper byte enables only matter to the timer registers.
    logic unused_be;
    assign unused_be   = ^data_be_i[3:1];
    assign timer_irq_o = 1'b0;
`endif

    assign data_rvalid_o  = rsp_q.valid;
    assign data_err_o     = rsp_q.err;
    assign data_rdata_o   = rsp_q.rdata;
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_tb_mmio_responder.sv
// tb_tb_mmio_responder
// Self-checking bench for tb_mmio_responder: a fixed vector table, directed
// multi-cycle sequences and randomized accesses compared with a reference
// model (counters derived from elapsed clock edges, a queue for stdout).
module tb_tb_mmio_responder;
    import tb_mmio_pkg::*;

    localparam logic [31:0] PASS_V = 32'd123456789;
    localparam logic [31:0] FAIL_V = 32'd1;
    localparam longint      PERIOD = 10;
`ifdef TB_MMIO_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk_i, rst_ni;
    logic        data_req_i, data_gnt_o, data_we_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o, exit_value_o;
    logic [3:0]  data_be_i;
    logic        data_rvalid_o, data_err_o;
    logic        char_valid_o, char_ready_i;
    logic [7:0]  char_data_o;
    logic        tests_passed_o, tests_failed_o, exit_valid_o, timer_irq_o;

    tb_mmio_responder dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .char_valid_o   (char_valid_o),
        .char_data_o    (char_data_o),
        .char_ready_i   (char_ready_i),
        .tests_passed_o (tests_passed_o),
        .tests_failed_o (tests_failed_o),
        .exit_valid_o   (exit_valid_o),
        .exit_value_o   (exit_value_o),
        .timer_irq_o    (timer_irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [2:0]  off;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [13];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_popped = 0;
    int          last_wait;
    logic [7:0]  exp_q [$];
    longint      efirst;
    logic [31:0] m_cmp, m_cnt_base, m_exit;
    longint      m_cnt_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Counter values seen by an access accepted at clock edge time e.
    function automatic logic [31:0] cycle_at(input longint e);
        return 32'((e - efirst) / PERIOD);
    endfunction

    function automatic logic [31:0] cnt_at(input longint e);
        return m_cnt_base + 32'((e - m_cnt_edge) / PERIOD);
    endfunction

    function automatic logic exp_err(input logic we, input logic [2:0] off);
        case (off)
            3'd0, 3'd1, 3'd2: return ~we;
            3'd3, 3'd4:       return ~TIMER_EN;
            3'd5:             return we;
            default:          return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_cmp      = '0;
        m_cnt_base = '0;
        m_cnt_edge = efirst;
        m_exit     = '0;
        exp_q.delete();
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_gnt"}, data_gnt_o, 0);
        check({tag, "_rvalid"}, data_rvalid_o, 0);
        check({tag, "_rdata"}, data_rdata_o, 0);
        check({tag, "_err"}, data_err_o, 0);
        check({tag, "_char_valid"}, char_valid_o, 0);
        check({tag, "_char_data"}, char_data_o, 0);
        check({tag, "_passed"}, tests_passed_o, 0);
        check({tag, "_failed"}, tests_failed_o, 0);
        check({tag, "_exit_valid"}, exit_valid_o, 0);
        check({tag, "_exit_value"}, exit_value_o, 0);
        check({tag, "_irq"}, timer_irq_o, 0);
    endtask

    // One OBI access. Entered just after a rising edge; returns 1 time unit
    // after the edge that delivers the response.
    task automatic xfer(input logic we, input logic [2:0] off, input logic [31:0] wd,
                        input logic [3:0] be, output logic got_err, output logic [31:0] got_rd);
        longint      ea;
        logic        e_err, e_pass, e_fail, e_exit;
        logic [31:0] e_rd;
        int          n;
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = 32'h1000_0000 | (32'(off) << 2);
        data_wdata_i = wd;
        data_be_i    = be;
        n = 0;
        @(negedge clk_i);
        while (data_gnt_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        last_wait = n;
        if (data_gnt_o !== 1'b1) begin
            check("gnt_timeout", data_gnt_o, 1);
            data_req_i = 1'b0;
            got_err    = 1'b1;
            got_rd     = '0;
            return;
        end
        @(posedge clk_i);
        ea     = longint'($time);
        e_err  = exp_err(we, off);
        e_rd   = '0;
        e_pass = 1'b0;
        e_fail = 1'b0;
        e_exit = 1'b0;
        if (!e_err && !we) begin
            case (off)
                3'd3:    e_rd = cnt_at(ea);
                3'd4:    e_rd = m_cmp;
                3'd5:    e_rd = cycle_at(ea);
                default: e_rd = '0;
            endcase
        end else if (!e_err) begin
            case (off)
                3'd0: if (be[0]) exp_q.push_back(wd[7:0]);
                3'd1: begin e_pass = (wd == PASS_V); e_fail = (wd == FAIL_V); end
                3'd2: begin e_exit = 1'b1; m_exit = wd; end
                3'd3: begin m_cnt_base = merge(cnt_at(ea), wd, be); m_cnt_edge = ea + PERIOD; end
                3'd4: m_cmp = merge(m_cmp, wd, be);
                default: ;
            endcase
        end
        #1;
        data_req_i = 1'b0;
        got_err    = data_err_o;
        got_rd     = data_rdata_o;
        check($sformatf("rvalid off%0d", off), data_rvalid_o, 1);
        check($sformatf("err off%0d we%0d", off, we), data_err_o, e_err);
        check($sformatf("rdata off%0d we%0d", off, we), data_rdata_o, e_rd);
        check("tests_passed", tests_passed_o, e_pass);
        check("tests_failed", tests_failed_o, e_fail);
        check("exit_valid", exit_valid_o, e_exit);
        check("exit_value", exit_value_o, m_exit);
`ifndef TB_MMIO_TIMER_EN
        check("irq_tied_low", timer_irq_o, 0);
`endif
    endtask

    // stdout consumer: every pop must match the next expected character.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && char_valid_o === 1'b1 && char_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("char_unexpected", char_valid_o, 0);
            end else begin
                check("char_data", char_data_o, exp_q.pop_front());
                n_popped++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        e;
        logic [31:0] r, r1, r2, wd;
        logic [2:0]  off;
        logic        we;
        logic [3:0]  be;
        int          n0, n;

        vecs[0]  = '{1'b0, OFF_PRINT,       32'h0,         4'hF, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, OFF_TEST_STATUS, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[2]  = '{1'b0, OFF_EXIT,        32'h0,         4'hF, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 3'd6,            32'h1234_5678, 4'hF, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 3'd7,            32'h0,         4'hF, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, OFF_CYCLE,       32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, OFF_TEST_STATUS, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, OFF_TIMER_CMP,   32'h1122_3344, 4'hF, ~TIMER_EN, 32'h0};
        vecs[8]  = '{1'b0, OFF_TIMER_CMP,   32'h0,         4'hF, ~TIMER_EN,
                     TIMER_EN ? 32'h1122_3344 : 32'h0};
        vecs[9]  = '{1'b1, OFF_TIMER_CMP,   32'hAABB_CCDD, 4'h5, ~TIMER_EN, 32'h0};
        vecs[10] = '{1'b0, OFF_TIMER_CMP,   32'h0,         4'hF, ~TIMER_EN,
                     TIMER_EN ? 32'h11BB_33DD : 32'h0};
        vecs[11] = '{1'b1, OFF_PRINT,       32'h5A,        4'h0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, OFF_TEST_STATUS, FAIL_V,        4'hF, 1'b0, 32'h0};

        rst_ni = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0;
        data_be_i = '0; data_wdata_i = '0; char_ready_i = 1'b1;
        efirst = 0;
        model_reset();

        // Power-on reset state.
        repeat (2) @(negedge clk_i);
        outputs_zero("por");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        efirst = longint'($time) - 1 + PERIOD;
        model_reset();

        // PASS signature: same-cycle grant, pulse for exactly one cycle.
        xfer(1'b1, OFF_TEST_STATUS, PASS_V, 4'hF, e, r);
        check("pass_gnt_wait", last_wait, 0);
        check("pass_pulse", tests_passed_o, 1);
        @(posedge clk_i); #1;
        check("pass_pulse_end", tests_passed_o, 0);
        check("pass_rvalid_end", data_rvalid_o, 0);

        // EXIT: one pulse, value held afterwards.
        xfer(1'b1, OFF_EXIT, 32'h2A, 4'hF, e, r);
        check("exit_pulse", exit_valid_o, 1);
        check("exit_code", exit_value_o, 32'h2A);
        repeat (10) begin
            @(posedge clk_i); #1;
            check("exit_pulse_low", exit_valid_o, 0);
        end
        check("exit_code_held", exit_value_o, 32'h2A);

        // Fixed vectors: decode errors, byte-lane merges, ignored writes.
        for (int i = 0; i < 13; i++) begin
            xfer(vecs[i].we, vecs[i].off, vecs[i].wd, vecs[i].be, e, r);
            check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
            check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rd);
        end

        // FIFO fill, stall on full, drain in order.
        char_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, OFF_PRINT, 32'h41 + 32'(i), 4'h1, e, r);
            check($sformatf("fifo_fill_wait%0d", i), last_wait, 0);
        end
        data_req_i = 1'b1; data_we_i = 1'b1; data_wdata_i = 32'h49; data_be_i = 4'h1;
        data_addr_i = 32'h1000_0000 | (32'(OFF_PRINT) << 2);
        repeat (3) begin
            @(negedge clk_i);
            check("fifo_full_stall", data_gnt_o, 0);
            check("fifo_head_valid", char_valid_o, 1);
            check("fifo_head_stable", char_data_o, 8'h41);
        end
        @(posedge clk_i); #1;
        char_ready_i = 1'b1;
        n0 = n_popped;
        xfer(1'b1, OFF_PRINT, 32'h49, 4'h1, e, r);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        @(negedge clk_i);
        check("fifo_drained", char_valid_o, 0);
        check("fifo_pop_count", 32'(n_popped - n0), 9);
        @(posedge clk_i); #1;

        // CYCLE: two reads 5 cycles apart, write rejected.
        xfer(1'b0, OFF_CYCLE, 32'h0, 4'hF, e, r1);
        repeat (4) begin @(posedge clk_i); #1; end
        xfer(1'b0, OFF_CYCLE, 32'h0, 4'hF, e, r2);
        check("cycle_delta", r2 - r1, 5);
        xfer(1'b1, OFF_CYCLE, 32'h0, 4'hF, e, r);
        check("cycle_write_err", e, 1);
        xfer(1'b0, OFF_CYCLE, 32'h0, 4'hF, e, r);

`ifdef TB_MMIO_TIMER_EN
        xfer(1'b1, OFF_TIMER_CMP, 32'd20, 4'hF, e, r);
        xfer(1'b1, OFF_TIMER_CNT, 32'd0, 4'hF, e, r);
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk_i); #1;
            check($sformatf("timer_irq_k%0d", k), timer_irq_o, 32'(k >= 21));
        end
        xfer(1'b1, OFF_TIMER_CMP, 32'd0, 4'hF, e, r);
        check("timer_irq_cleared", timer_irq_o, 0);
        xfer(1'b0, OFF_TIMER_CNT, 32'h0, 4'hF, e, r);
`else
        xfer(1'b0, OFF_TIMER_CMP, 32'h0, 4'hF, e, r);
        check("cmp_read_err", e, 1);
        check("irq_low", timer_irq_o, 0);
`endif

        // Randomized accesses against the model.
        for (int i = 0; i < 150; i++) begin
            off = 3'($urandom_range(0, 7));
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            be  = 4'($urandom_range(0, 15));
            if (off == OFF_TEST_STATUS) begin
                case ($urandom_range(0, 2))
                    0:       wd = PASS_V;
                    1:       wd = FAIL_V;
                    default: ;
                endcase
            end
            if ($urandom_range(0, 3) == 0) begin @(posedge clk_i); #1; end
            xfer(we, off, wd, be, e, r);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        @(negedge clk_i);
        check("random_fifo_drained", char_valid_o, 0);
        @(posedge clk_i); #1;

        // Reset right after a granted read: the response is dropped.
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF;
        data_addr_i = 32'h1000_0000 | (32'(OFF_CYCLE) << 2);
        @(negedge clk_i);
        check("rst_read_gnt", data_gnt_o, 1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        data_req_i = 1'b0;
        @(negedge clk_i);
        outputs_zero("rst_mid");
        @(posedge clk_i); #1;
        @(negedge clk_i);
        outputs_zero("rst_hold");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        efirst = longint'($time) - 1 + PERIOD;
        model_reset();
        repeat (2) begin
            @(negedge clk_i);
            check("rst_no_rvalid", data_rvalid_o, 0);
        end
        @(posedge clk_i); #1;
        xfer(1'b0, OFF_CYCLE, 32'h0, 4'hF, e, r);
        xfer(1'b0, OFF_TIMER_CMP, 32'h0, 4'hF, e, r);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
